// File: rtl/fb_write_arbiter_if.sv
// Bundle of requester-side and framebuffer-side signals around the write arbiter.
// The arbiter takes the slave view; the drawers/framebuffer environment takes the master view.
interface fb_write_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_i;
  logic [N_REQ*8-1:0]  req_x_i;
  logic [N_REQ*9-1:0]  req_y_i;
  logic [N_REQ*16-1:0] req_color_i;
  logic [N_REQ-1:0]    ack_o;
  logic [7:0]          fb_x_o;
  logic [8:0]          fb_y_o;
  logic [15:0]         fb_color_o;
  logic                fb_req_o;
  logic                fb_ack_i;
  logic                busy_o;

  modport slave (
    input  req_i, req_x_i, req_y_i, req_color_i, fb_ack_i,
    output ack_o, fb_x_o, fb_y_o, fb_color_o, fb_req_o, busy_o
  );

  modport master (
    output req_i, req_x_i, req_y_i, req_color_i, fb_ack_i,
    input  ack_o, fb_x_o, fb_y_o, fb_color_o, fb_req_o, busy_o
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port among N_REQ drawing engines.
// One pixel per grant: IDLE -> WAIT_FB (until fb_ack_i) -> ACK (one-cycle ack) -> IDLE.
module fb_write_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  fb_write_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_FB, ACK} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic [N_REQ-1:0] ack;
  logic             fb_req;
  logic             busy;
  logic [7:0]       fb_x;
  logic [8:0]       fb_y;
  logic [15:0]      fb_color;

  logic             found;
  logic [PTR_W-1:0] pick;
  logic [7:0]       sel_x;
  logic [8:0]       sel_y;
  logic [15:0]      sel_color;

  // First set request at or above ptr, wrapping explicitly since N_REQ may not be a power of 2
  always_comb begin
    found     = 1'b0;
    pick      = ptr;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && bus.req_i[j]) begin
        found     = 1'b1;
        pick      = PTR_W'(j);
        sel_x     = bus.req_x_i[8*j +: 8];
        sel_y     = bus.req_y_i[9*j +: 9];
        sel_color = bus.req_color_i[16*j +: 16];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      ack      <= '0;
      fb_req   <= 1'b0;
      busy     <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick;
            fb_x     <= sel_x;
            fb_y     <= sel_y;
            fb_color <= sel_color;
            fb_req   <= 1'b1;
            busy     <= 1'b1;
            state    <= WAIT_FB;
          end
        end
        WAIT_FB: begin
          if (bus.fb_ack_i) begin
            fb_req <= 1'b0;
            ack    <= N_REQ'(1) << grant;
            ptr    <= (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          // Requests are deliberately not sampled here so a stale request of the granted engine is not re-served
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          fb_req <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o      = ack;
  assign bus.fb_req_o   = fb_req;
  assign bus.busy_o     = busy;
  assign bus.fb_x_o     = fb_x;
  assign bus.fb_y_o     = fb_y;
  assign bus.fb_color_o = fb_color;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level round-robin model of the requesters and pointer.
module tb_fb_write_arbiter;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fb_write_arbiter_if #(.N_REQ(N)) bus ();

  fb_write_arbiter #(.N_REQ(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who is requesting, what pixel each holds, and the round-robin pointer
  bit          mreq [N];
  logic [7:0]  mx   [N];
  logic [8:0]  my   [N];
  logic [15:0] mc   [N];
  int          ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_i[k]                 = mreq[k];
      bus.req_x_i[8*k +: 8]        = mx[k];
      bus.req_y_i[9*k +: 9]        = my[k];
      bus.req_color_i[16*k +: 16]  = mc[k];
    end
  endtask

  task automatic set_pixel(input int k);
    mx[k] = 8'($urandom);
    my[k] = 9'($urandom);
    mc[k] = 16'($urandom);
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      if (mreq[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One complete write starting from IDLE with the request vector already driven.
  task automatic do_write(input int delay, input bit keep, input logic [N-1:0] raise);
    int g;
    g = pick();
    if (g < 0) begin
      check("model_has_request", 32'(0), 32'(1));
      return;
    end
    tick();
    check("fb_req_rise", 32'(bus.fb_req_o), 32'(1));
    check("busy_wait", 32'(bus.busy_o), 32'(1));
    check("ack_wait", 32'(bus.ack_o), 32'(0));
    check("fb_x", 32'(bus.fb_x_o), 32'(mx[g]));
    check("fb_y", 32'(bus.fb_y_o), 32'(my[g]));
    check("fb_color", 32'(bus.fb_color_o), 32'(mc[g]));
    for (int d = 0; d < delay; d++) begin
      tick();
      check("fb_req_hold", 32'(bus.fb_req_o), 32'(1));
      check("fb_x_hold", 32'(bus.fb_x_o), 32'(mx[g]));
      check("fb_color_hold", 32'(bus.fb_color_o), 32'(mc[g]));
      check("ack_hold", 32'(bus.ack_o), 32'(0));
    end
    bus.fb_ack_i = 1'b1;
    tick();
    bus.fb_ack_i = 1'b0;
    check("fb_req_in_ack", 32'(bus.fb_req_o), 32'(0));
    check("ack_grant", 32'(bus.ack_o), 32'(1) << g);
    check("busy_ack", 32'(bus.busy_o), 32'(1));
    ptr = (g + 1) % N;
    if (keep) set_pixel(g);
    else mreq[g] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (raise[k] && !mreq[k]) begin
        mreq[k] = 1'b1;
        set_pixel(k);
      end
    end
    drive();
    tick();
    check("ack_single_cycle", 32'(bus.ack_o), 32'(0));
    check("fb_req_idle", 32'(bus.fb_req_o), 32'(0));
    check("busy_idle", 32'(bus.busy_o), 32'(0));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      mreq[k] = 1'b0;
      mx[k] = '0;
      my[k] = '0;
      mc[k] = '0;
    end
    bus.fb_ack_i = 1'b0;
    drive();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'(0));
    check("rst_fb_req", 32'(bus.fb_req_o), 32'(0));
    check("rst_busy", 32'(bus.busy_o), 32'(0));
    check("rst_fb_x", 32'(bus.fb_x_o), 32'(0));
    check("rst_fb_y", 32'(bus.fb_y_o), 32'(0));
    check("rst_fb_color", 32'(bus.fb_color_o), 32'(0));
    reset_n = 1'b1;
    tick();
    check("idle_no_req", 32'(bus.fb_req_o), 32'(0));

    // Single requester: 10/300/F800, fb_ack two cycles late
    mreq[0] = 1'b1; mx[0] = 8'd10; my[0] = 9'd300; mc[0] = 16'hF800;
    drive();
    do_write(2, 1'b0, '0);

    // Round robin with all four held, immediate fb_ack; last lap drops each after its ack
    for (int k = 0; k < N; k++) begin
      mreq[k] = 1'b1;
      set_pixel(k);
    end
    drive();
    for (int n = 0; n < 2 * N; n++) do_write(0, n < N, '0);

    // Pointer wrap: grant 2 leaves ptr=3, then 1001 gives 3 then 0
    mreq[2] = 1'b1; set_pixel(2);
    drive();
    do_write(0, 1'b0, '0);
    check("ptr_after_2", 32'(ptr), 32'(3));
    mreq[0] = 1'b1; set_pixel(0);
    mreq[3] = 1'b1; set_pixel(3);
    drive();
    do_write(0, 1'b0, '0);
    do_write(0, 1'b0, '0);

    // Back-to-back requester 1 with a new pixel while requester 3 joins
    mreq[1] = 1'b1; set_pixel(1);
    drive();
    do_write(1, 1'b1, 4'b1000);
    do_write(0, 1'b0, '0);
    do_write(0, 1'b0, '0);

    // Stray fb_ack in IDLE
    bus.fb_ack_i = 1'b1;
    tick();
    check("stray_ack", 32'(bus.ack_o), 32'(0));
    check("stray_fb_req", 32'(bus.fb_req_o), 32'(0));
    tick();
    check("stray_busy", 32'(bus.busy_o), 32'(0));
    bus.fb_ack_i = 1'b0;
    mreq[2] = 1'b1; set_pixel(2);
    drive();
    do_write(0, 1'b0, '0);

    // Reset while WAIT_FB
    mreq[0] = 1'b1; set_pixel(0);
    drive();
    tick();
    check("pre_reset_fb_req", 32'(bus.fb_req_o), 32'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_fb_req", 32'(bus.fb_req_o), 32'(0));
    check("midrst_ack", 32'(bus.ack_o), 32'(0));
    check("midrst_busy", 32'(bus.busy_o), 32'(0));
    ptr = 0;
    mreq[0] = 1'b0;
    mreq[2] = 1'b1; set_pixel(2);
    drive();
    #2;
    reset_n = 1'b1;
    do_write(0, 1'b0, '0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if (pick() < 0) begin
        int k;
        k = int'($urandom_range(0, N - 1));
        mreq[k] = 1'b1;
        set_pixel(k);
        drive();
      end
      do_write(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), N'($urandom & $urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
